// File: rtl/axis_word_sequencer.sv
// Producer side of the axis word link: captures an X/Y/Z sample set and streams it as
// tagged words (2=X, 1=Y, 0=Z) with a one-deep pending buffer. Option: AXIS_CHECKSUM_EN.
module axis_word_sequencer #(
    parameter int DATA_W  = 16,
    parameter int GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] X_In,
    input  logic [DATA_W-1:0] Y_In,
    input  logic [DATA_W-1:0] Z_In,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] DataOut,
    output logic [1:0]        o_Byte_Count,
    output logic              Load,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

`ifdef AXIS_CHECKSUM_EN
    localparam logic [1:0] FIRST_CNT = 2'd3;
`else
    localparam logic [1:0] FIRST_CNT = 2'd2;
`endif
    localparam bit         HAS_GAP  = (GAP_CYC != 0);
    localparam logic [7:0] GAP_LOAD = HAS_GAP ? 8'(GAP_CYC - 1) : 8'd0;

    state_t            state_reg, state_next;
    logic [1:0]        count_reg, count_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [7:0]        gap_reg, gap_next;
    logic              overrun_reg, overrun_next;
    logic              pend_full_reg, pend_full_next;

    logic [DATA_W-1:0] act_x_reg, act_y_reg, act_z_reg, act_k_reg;
    logic [DATA_W-1:0] pend_x_reg, pend_y_reg, pend_z_reg, pend_k_reg;

    logic [DATA_W-1:0] in_k;
    logic [DATA_W-1:0] eff_x, eff_y, eff_z, eff_k;
    logic              frame_end;
    logic              act_load;
    logic              pend_wr;

`ifdef AXIS_CHECKSUM_EN
    assign in_k = X_In ^ Y_In ^ Z_In;
`else
    assign in_k = '0;
`endif

    // Set that would start a new frame: a fresh strobe always wins over the pending copy.
    assign eff_x = sample_valid ? X_In : pend_x_reg;
    assign eff_y = sample_valid ? Y_In : pend_y_reg;
    assign eff_z = sample_valid ? Z_In : pend_z_reg;
    assign eff_k = sample_valid ? in_k : pend_k_reg;

    function automatic logic [DATA_W-1:0] pick(input logic [1:0] c,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y,
                                               input logic [DATA_W-1:0] z,
                                               input logic [DATA_W-1:0] k);
        case (c)
            2'd2:    pick = x;
            2'd1:    pick = y;
            2'd0:    pick = z;
            default: pick = k;
        endcase
    endfunction

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        data_next      = data_reg;
        gap_next       = gap_reg;
        overrun_next   = 1'b0;
        pend_full_next = pend_full_reg;
        frame_end      = 1'b0;
        act_load       = 1'b0;
        pend_wr        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sample_valid) begin
                    state_next = SEND;
                    count_next = FIRST_CNT;
                    data_next  = pick(FIRST_CNT, eff_x, eff_y, eff_z, eff_k);
                    act_load   = 1'b1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (HAS_GAP) begin
                        state_next = GAP;
                        gap_next   = GAP_LOAD;
                    end else if (count_reg != 2'd0) begin
                        count_next = count_reg - 2'd1;
                        data_next  = pick(count_reg - 2'd1, act_x_reg, act_y_reg,
                                          act_z_reg, act_k_reg);
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            GAP: begin
                // count_reg still tags the word just sent; zero means the frame is complete.
                if (gap_reg != 8'd0) begin
                    gap_next = gap_reg - 8'd1;
                end else if (count_reg != 2'd0) begin
                    state_next = SEND;
                    count_next = count_reg - 2'd1;
                    data_next  = pick(count_reg - 2'd1, act_x_reg, act_y_reg,
                                      act_z_reg, act_k_reg);
                end else begin
                    frame_end = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (frame_end) begin
            if (sample_valid || pend_full_reg) begin
                state_next     = SEND;
                count_next     = FIRST_CNT;
                data_next      = pick(FIRST_CNT, eff_x, eff_y, eff_z, eff_k);
                act_load       = 1'b1;
                pend_full_next = 1'b0;
                overrun_next   = sample_valid && pend_full_reg;
            end else begin
                state_next = IDLE;
                count_next = 2'd0;
            end
        end else if (state_reg != IDLE && sample_valid) begin
            pend_wr        = 1'b1;
            pend_full_next = 1'b1;
            overrun_next   = pend_full_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= 2'd0;
            data_reg      <= '0;
            gap_reg       <= 8'd0;
            overrun_reg   <= 1'b0;
            pend_full_reg <= 1'b0;
            act_x_reg     <= '0;
            act_y_reg     <= '0;
            act_z_reg     <= '0;
            act_k_reg     <= '0;
            pend_x_reg    <= '0;
            pend_y_reg    <= '0;
            pend_z_reg    <= '0;
            pend_k_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            data_reg      <= data_next;
            gap_reg       <= gap_next;
            overrun_reg   <= overrun_next;
            pend_full_reg <= pend_full_next;
            if (act_load) begin
                act_x_reg <= eff_x;
                act_y_reg <= eff_y;
                act_z_reg <= eff_z;
                act_k_reg <= eff_k;
            end
            if (pend_wr) begin
                pend_x_reg <= X_In;
                pend_y_reg <= Y_In;
                pend_z_reg <= Z_In;
                pend_k_reg <= in_k;
            end
        end
    end

    assign DataOut      = data_reg;
    assign o_Byte_Count = count_reg;
    assign Load         = (state_reg == SEND);
    assign busy         = (state_reg != IDLE);
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_axis_word_sequencer.sv
// Directed bench for axis_word_sequencer: one instance with no gap, one with GAP_CYC=3.
// Frame expectations follow AXIS_CHECKSUM_EN when the bench is built with it.
module tb_axis_word_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        sv0 = 1'b0, rdy0 = 1'b0;
    logic [15:0] x0 = '0, y0 = '0, z0 = '0;
    logic [15:0] dout0;
    logic [1:0]  cnt0;
    logic        load0, busy0, ovr0;

    logic        sv3 = 1'b0, rdy3 = 1'b0;
    logic [15:0] x3 = '0, y3 = '0, z3 = '0;
    logic [15:0] dout3;
    logic [1:0]  cnt3;
    logic        load3, busy3, ovr3;

    int total = 0;
    int bad   = 0;

    logic [15:0] wd [4];
    logic [1:0]  wc [4];
    int          nw;

    always #5 clk = ~clk;

    axis_word_sequencer #(.DATA_W(16), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv0),
        .X_In(x0), .Y_In(y0), .Z_In(z0), .tx_ready(rdy0),
        .DataOut(dout0), .o_Byte_Count(cnt0), .Load(load0),
        .busy(busy0), .overrun(ovr0)
    );

    axis_word_sequencer #(.DATA_W(16), .GAP_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv3),
        .X_In(x3), .Y_In(y3), .Z_In(z3), .tx_ready(rdy3),
        .DataOut(dout3), .o_Byte_Count(cnt3), .Load(load3),
        .busy(busy3), .overrun(ovr3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s val=%h", tag, got);
        end
    endtask

    function automatic logic [31:0] pk(input logic ld, input logic bz, input logic [1:0] c,
                                       input logic [15:0] d);
        pk = {12'd0, ld, bz, c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected word sequence for one frame.
    task automatic build(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
`ifdef AXIS_CHECKSUM_EN
        wd[0] = x ^ y ^ z; wc[0] = 2'd3;
        wd[1] = x; wc[1] = 2'd2;
        wd[2] = y; wc[2] = 2'd1;
        wd[3] = z; wc[3] = 2'd0;
        nw = 4;
`else
        wd[0] = x; wc[0] = 2'd2;
        wd[1] = y; wc[1] = 2'd1;
        wd[2] = z; wc[2] = 2'd0;
        wd[3] = '0; wc[3] = 2'd0;
        nw = 3;
`endif
    endtask

    // With rdy0 high, expects the whole frame offered on consecutive cycles from now.
    task automatic walk0(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z);
        build(x, y, z);
        for (int i = 0; i < nw; i++) begin
            check_val($sformatf("%s_w%0d", tag, i), pk(load0, busy0, cnt0, dout0),
                      pk(1'b1, 1'b1, wc[i], wd[i]));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) tick();
        check_val("rst_dut0", pk(load0, busy0, cnt0, dout0) | {31'd0, ovr0} << 20, 32'd0);
        check_val("rst_dut3", pk(load3, busy3, cnt3, dout3) | {31'd0, ovr3} << 20, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic three-word frame, back-to-back transfers
        rdy0 = 1'b1;
        sv0 = 1'b1; x0 = 16'h1234; y0 = 16'h5678; z0 = 16'h9ABC;
        tick();
        sv0 = 1'b0;
        walk0("basic", 16'h1234, 16'h5678, 16'h9ABC);
        check_val("basic_idle", pk(load0, busy0, cnt0, dout0), pk(1'b0, 1'b0, 2'd0, 16'h9ABC));

        // backpressure while Y is offered
        sv0 = 1'b1;
        tick();
        sv0 = 1'b0;
        build(16'h1234, 16'h5678, 16'h9ABC);
        repeat (nw - 2) tick();
        rdy0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp_hold%0d", i), pk(load0, busy0, cnt0, dout0),
                      pk(1'b1, 1'b1, 2'd1, 16'h5678));
            tick();
        end
        rdy0 = 1'b1;
        tick();
        check_val("bp_z", pk(load0, busy0, cnt0, dout0), pk(1'b1, 1'b1, 2'd0, 16'h9ABC));
        tick();
        check_val("bp_idle", pk(load0, busy0, cnt0, dout0), pk(1'b0, 1'b0, 2'd0, 16'h9ABC));

        // pending/overrun: A active, C overwrites B
        rdy0 = 1'b0;
        sv0 = 1'b1; x0 = 16'hA001; y0 = 16'hA002; z0 = 16'hA003;
        tick();
        x0 = 16'hB001; y0 = 16'hB002; z0 = 16'hB003;
        check_val("ovr_a_no", {31'd0, ovr0}, 32'd0);
        tick();
        x0 = 16'hC001; y0 = 16'hC002; z0 = 16'hC003;
        check_val("ovr_b_no", {31'd0, ovr0}, 32'd0);
        tick();
        sv0 = 1'b0;
        check_val("ovr_pulse", {31'd0, ovr0}, 32'd1);
        build(16'hA001, 16'hA002, 16'hA003);
        check_val("ovr_a_held", pk(load0, busy0, cnt0, dout0), pk(1'b1, 1'b1, wc[0], wd[0]));
        tick();
        check_val("ovr_clear", {31'd0, ovr0}, 32'd0);
        rdy0 = 1'b1;
        walk0("ovr_a", 16'hA001, 16'hA002, 16'hA003);
        walk0("ovr_c", 16'hC001, 16'hC002, 16'hC003);
        check_val("ovr_idle", {30'd0, load0, busy0}, 32'd0);

        // strobe in the cycle the last word transfers
        sv0 = 1'b1; x0 = 16'hD001; y0 = 16'hD002; z0 = 16'hD003;
        tick();
        sv0 = 1'b0;
        build(16'hD001, 16'hD002, 16'hD003);
        repeat (nw - 1) tick();
        sv0 = 1'b1; x0 = 16'hE001; y0 = 16'hE002; z0 = 16'hE003;
        tick();
        sv0 = 1'b0;
        check_val("last_sv_no_ovr", {31'd0, ovr0}, 32'd0);
        walk0("last_sv_e", 16'hE001, 16'hE002, 16'hE003);
        check_val("last_sv_idle", {30'd0, load0, busy0}, 32'd0);

        // GAP_CYC=3 instance
        rdy3 = 1'b1;
        sv3 = 1'b1; x3 = 16'h1111; y3 = 16'h2222; z3 = 16'h3333;
        tick();
        sv3 = 1'b0;
        build(16'h1111, 16'h2222, 16'h3333);
        for (int i = 0; i < nw; i++) begin
            check_val($sformatf("gap_w%0d", i), pk(load3, busy3, cnt3, dout3),
                      pk(1'b1, 1'b1, wc[i], wd[i]));
            tick();
            for (int g = 0; g < 3; g++) begin
                check_val($sformatf("gap_w%0d_g%0d", i, g), {14'd0, load3, busy3, dout3},
                          {14'd0, 1'b0, 1'b1, wd[i]});
                tick();
            end
        end
        check_val("gap_idle", pk(load3, busy3, cnt3, dout3), pk(1'b0, 1'b0, 2'd0, 16'h3333));

        // asynchronous reset mid-frame
        rdy0 = 1'b0;
        sv0 = 1'b1; x0 = 16'h4444; y0 = 16'h5555; z0 = 16'h6666;
        tick();
        sv0 = 1'b0;
        check_val("mid_pre", {31'd0, load0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_async", pk(load0, busy0, cnt0, dout0) | {31'd0, ovr0} << 20, 32'd0);
        tick();
        rst_n = 1'b1;
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("mid_after%0d", i), {30'd0, load0, busy0}, 32'd0);
        end

`ifdef AXIS_CHECKSUM_EN
        sv0 = 1'b1; x0 = 16'h00FF; y0 = 16'h0F0F; z0 = 16'hF000;
        tick();
        sv0 = 1'b0;
        check_val("ck_sum", pk(load0, busy0, cnt0, dout0), pk(1'b1, 1'b1, 2'd3, 16'hFFF0));
        tick();
        check_val("ck_x", pk(load0, busy0, cnt0, dout0), pk(1'b1, 1'b1, 2'd2, 16'h00FF));
        tick();
        check_val("ck_y", pk(load0, busy0, cnt0, dout0), pk(1'b1, 1'b1, 2'd1, 16'h0F0F));
        tick();
        check_val("ck_z", pk(load0, busy0, cnt0, dout0), pk(1'b1, 1'b1, 2'd0, 16'hF000));
        tick();
        check_val("ck_idle", {30'd0, load0, busy0}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
